// File: rtl/l2_arbiter.sv
// Purpose : two-client (icache/dcache) round-robin arbiter onto the single word-wide L2 request port.
// Latency : grant is registered (request seen in cycle N is on l2_req_* in N+1); request/response routing is combinational.
// Backpressure: level handshake, clients hold valid until fulfilled; a grant is released after MAX_GRANT_BEATS beats if the other client waits.
//
// Ports:
//   clk, reset         clock and asynchronous active-low reset (0 = in reset)
//   ic_req_* / ic_*    icache request in, fetched word / beat-complete out
//   dc_req_* / dc_*    dcache request in, fetched word / beat-complete out
//   l2_req_* / l2_*    request out to L2, fetched word / beat-complete in
//   *_req_type         memory operation: 0 = LOAD, 1 = STORE
module l2_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_GRANT_BEATS = 8
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [XLEN-1:0] ic_req_address,
    input  logic            ic_req_type,
    input  logic            ic_req_valid,
    input  logic [XLEN-1:0] ic_word_to_store,
    output logic [XLEN-1:0] ic_fetched_word,
    output logic            ic_req_fulfilled,

    input  logic [XLEN-1:0] dc_req_address,
    input  logic            dc_req_type,
    input  logic            dc_req_valid,
    input  logic [XLEN-1:0] dc_word_to_store,
    output logic [XLEN-1:0] dc_fetched_word,
    output logic            dc_req_fulfilled,

    output logic [XLEN-1:0] l2_req_address,
    output logic            l2_req_type,
    output logic            l2_req_valid,
    output logic [XLEN-1:0] l2_word_to_store,
    input  logic [XLEN-1:0] l2_fetched_word,
    input  logic            l2_req_fulfilled
);

    localparam logic OP_LOAD = 1'b0;
    localparam int   CW      = $clog2(MAX_GRANT_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IC = 2'd1,
        GRANT_DC = 2'd2
    } state_t;

    state_t        state;
    logic          last_grant_dc;   // 1: dcache held the most recent grant
    logic [CW-1:0] beat_cnt;
    logic          last_beat;

    // Compared against MAX-1 rather than computing beat_cnt+1, so the
    // counter never needs a carry bit and never reaches MAX_GRANT_BEATS.
    assign last_beat = (beat_cnt == CW'(MAX_GRANT_BEATS - 1));

    // Grant state. Outputs below depend only on this registered state and
    // the live inputs, so l2_req_fulfilled can never reach l2_req_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_grant_dc <= 1'b1;   // icache wins the first tie
            beat_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ic_req_valid && (!dc_req_valid || last_grant_dc)) begin
                        state    <= GRANT_IC;
                        beat_cnt <= '0;
                    end else if (dc_req_valid) begin
                        state    <= GRANT_DC;
                        beat_cnt <= '0;
                    end
                end
                GRANT_IC: begin
                    if (!ic_req_valid) begin
                        state         <= IDLE;
                        last_grant_dc <= 1'b0;
                    end else if (l2_req_fulfilled) begin
                        if (last_beat) begin
                            // Yield only if the dcache is actually waiting;
                            // otherwise keep streaming with a fresh budget.
                            if (dc_req_valid) begin
                                state         <= IDLE;
                                last_grant_dc <= 1'b0;
                            end else begin
                                beat_cnt <= '0;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                GRANT_DC: begin
                    if (!dc_req_valid) begin
                        state         <= IDLE;
                        last_grant_dc <= 1'b1;
                    end else if (l2_req_fulfilled) begin
                        if (last_beat) begin
                            if (ic_req_valid) begin
                                state         <= IDLE;
                                last_grant_dc <= 1'b1;
                            end else begin
                                beat_cnt <= '0;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Request/response routing. Because the state resets asynchronously,
    // asserting reset mid-grant drops l2_req_valid immediately.
    always_comb begin
        l2_req_address   = '0;
        l2_req_type      = OP_LOAD;
        l2_req_valid     = 1'b0;
        l2_word_to_store = '0;
        ic_fetched_word  = '0;
        ic_req_fulfilled = 1'b0;
        dc_fetched_word  = '0;
        dc_req_fulfilled = 1'b0;
        case (state)
            GRANT_IC: begin
                l2_req_address   = ic_req_address;
                l2_req_type      = ic_req_type;
                l2_req_valid     = ic_req_valid;
                l2_word_to_store = ic_word_to_store;
                ic_fetched_word  = l2_fetched_word;
                ic_req_fulfilled = l2_req_fulfilled & ic_req_valid;
            end
            GRANT_DC: begin
                l2_req_address   = dc_req_address;
                l2_req_type      = dc_req_type;
                l2_req_valid     = dc_req_valid;
                l2_word_to_store = dc_word_to_store;
                dc_fetched_word  = l2_fetched_word;
                dc_req_fulfilled = l2_req_fulfilled & dc_req_valid;
            end
            default: begin
                // IDLE: a stray l2_req_fulfilled is dropped here.
            end
        endcase
    end

endmodule
